offset_tuner: RTL and testbench



---
 rtl/clock_pkg.sv | 56 +++++
 rtl/offset_tuner_if.sv | 22 ++
 rtl/key_repeat.sv | 98 +++++++++
 rtl/offset_tuner.sv | 124 ++++++++++++
 tb/tb_offset_tuner.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared constants and helpers for the time-keeping block: system states, key codes, offset bias and field steps.
// No logic, no latency.
// No flow control.
package clock_pkg;

   typedef enum logic [2:0] {
      S_INIT        = 3'd0,
      S_NORMAL      = 3'd1,
      S_PAUSED      = 3'd2,
      S_TUNING      = 3'd3,
      S_ALARMSET    = 3'd4,
      S_ALARMTUNING = 3'd5,
      S_ALARMING    = 3'd6
   } status_e;

   localparam logic [3:0] K_UP      = 4'b0001;
   localparam logic [3:0] K_DOWN    = 4'b0010;
   localparam logic [3:0] K_SEL     = 4'b0100;
   localparam logic [3:0] K_CONFIRM = 4'b1000;

   localparam int unsigned SEC_PER_DAY = 86400;

   // Offsets are biased so OFFSET_INIT means "no change"
   localparam logic [19:0]        OFFSET_INIT = 20'h7ffff;
   localparam logic [19:0]        MAX_DELTA   = 20'(SEC_PER_DAY - 1);
   localparam logic signed [20:0] MAX_DELTA_S = $signed({1'b0, MAX_DELTA});
   localparam logic [19:0]        OFFSET_MAX  = OFFSET_INIT + MAX_DELTA;
   localparam logic [19:0]        OFFSET_MIN  = OFFSET_INIT - MAX_DELTA;

   typedef enum logic [1:0] {
      FIELD_SEC  = 2'd0,
      FIELD_MIN  = 2'd1,
      FIELD_HOUR = 2'd2
   } field_e;

   localparam logic [19:0] STEP_SEC  = 20'd1;
   localparam logic [19:0] STEP_MIN  = 20'd60;
   localparam logic [19:0] STEP_HOUR = 20'd3600;

   function automatic logic [19:0] step_of(field_e f);
      case (f)
         FIELD_MIN:  return STEP_MIN;
         FIELD_HOUR: return STEP_HOUR;
         default:    return STEP_SEC;
      endcase
   endfunction

   function automatic field_e next_field(field_e f);
      case (f)
         FIELD_SEC: return FIELD_MIN;
         FIELD_MIN: return FIELD_HOUR;
         default:   return FIELD_SEC;
      endcase
   endfunction

endpackage

// File: rtl/offset_tuner_if.sv
// Bundle of the tuner's key/status inputs and its offset/display outputs.
// No logic, no latency.
// No flow control; plain level and pulse signals.
interface offset_tuner_if;
   logic [2:0]  sys_status;
   logic [3:0]  neg_keys_filtered;
   logic [3:0]  keys_held;
   logic [19:0] offset;
   logic [1:0]  field_sel;
   logic        blink;
   logic        tuning;

   modport master (
      output sys_status, neg_keys_filtered, keys_held,
      input  offset, field_sel, blink, tuning
   );

   modport slave (
      input  sys_status, neg_keys_filtered, keys_held,
      output offset, field_sel, blink, tuning
   );
endinterface

// File: rtl/key_repeat.sv
// Press-and-hold auto-repeat: turns a held UP/DOWN key into periodic step ticks.
// Ticks are combinational from registered state; first tick HOLD_CYCLES cycles after the pulse.
// No backpressure; release, a foreign held key or en low drops back to idle silently.
module key_repeat
   import clock_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES   = 25_000_000,
   parameter int unsigned REPEAT_CYCLES = 5_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       up_pulse,
   input  logic       down_pulse,
   input  logic [3:0] keys_held,
   output logic       up_tick,
   output logic       down_tick
);

   typedef enum logic [1:0] {RPT_IDLE, RPT_WAIT, RPT_REPEAT} rpt_e;

   rpt_e        state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic        dir_q, dir_d;     // 1 = down
   logic        held_ok;
   logic        any_pulse;

   // Only the latched direction key may be held; anything else cancels the repeat
   assign held_ok   = (keys_held == (dir_q ? K_DOWN : K_UP));
   assign any_pulse = up_pulse | down_pulse;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RPT_IDLE;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
      end
   end

   // Next state: a fresh pulse always restarts the hold wait with its own direction
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      if (!en) begin
         state_d = RPT_IDLE;
         cnt_d   = '0;
      end else if (any_pulse) begin
         state_d = RPT_WAIT;
         cnt_d   = '0;
         dir_d   = down_pulse;
      end else begin
         case (state_q)
            RPT_WAIT: begin
               if (!held_ok) begin
                  state_d = RPT_IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == HOLD_CYCLES - 1) begin
                  state_d = RPT_REPEAT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end
            RPT_REPEAT: begin
               if (!held_ok) begin
                  state_d = RPT_IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == REPEAT_CYCLES - 1) begin
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end
            default: begin
               state_d = RPT_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Outputs: a tick fires on the terminal count while still validly held, never alongside a pulse
   always_comb begin
      logic tick;
      tick = en && !any_pulse && held_ok &&
             (((state_q == RPT_WAIT)   && (cnt_q == HOLD_CYCLES - 1)) ||
              ((state_q == RPT_REPEAT) && (cnt_q == REPEAT_CYCLES - 1)));
      up_tick   = tick && !dir_q;
      down_tick = tick &&  dir_q;
   end

endmodule

// File: rtl/offset_tuner.sv
// Turns key events into a saturating, biased time offset with field select and blink for the display.
// Offset/field/blink update one cycle after the key pulse; tuning lags sys_status by one cycle.
// No backpressure; non-one-hot key pulses are dropped for that cycle.
module offset_tuner
   import clock_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES   = 25_000_000,
   parameter int unsigned REPEAT_CYCLES = 5_000_000,
   parameter int unsigned BLINK_HALF    = 25_000_000
) (
   input  logic             clk,
   input  logic             rst_n,
   offset_tuner_if.slave    bus
);

   logic        tuning_q, tuning_d;
   logic [19:0] offset_q, offset_d;
   field_e      field_q, field_d;
   logic        blink_q, blink_d;
   logic [31:0] blink_cnt_q, blink_cnt_d;

   logic key_up_p, key_dn_p, key_sel_p, key_cf_p;
   logic up_tick, down_tick;
   logic edit;

   logic [19:0]        step_w;
   logic signed [20:0] delta, delta_up, delta_dn;
   logic [19:0]        off_up, off_dn;

   // Keys are only meaningful once the registered tuning flag is up
   assign key_up_p  = tuning_q && (bus.neg_keys_filtered == K_UP);
   assign key_dn_p  = tuning_q && (bus.neg_keys_filtered == K_DOWN);
   assign key_sel_p = tuning_q && (bus.neg_keys_filtered == K_SEL);
   assign key_cf_p  = tuning_q && (bus.neg_keys_filtered == K_CONFIRM);

   key_repeat #(
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
   ) u_key_repeat (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (tuning_q && tuning_d),
      .up_pulse   (key_up_p),
      .down_pulse (key_dn_p),
      .keys_held  (bus.keys_held),
      .up_tick    (up_tick),
      .down_tick  (down_tick)
   );

   // Saturating step candidates, judged on the signed distance from the bias point
   always_comb begin
      step_w   = step_of(field_q);
      delta    = $signed({1'b0, offset_q}) - $signed({1'b0, OFFSET_INIT});
      delta_up = delta + $signed({1'b0, step_w});
      delta_dn = delta - $signed({1'b0, step_w});
      off_up   = (delta_up > MAX_DELTA_S)  ? OFFSET_MAX : offset_q + step_w;
      off_dn   = (delta_dn < -MAX_DELTA_S) ? OFFSET_MIN : offset_q - step_w;
   end

   // Next state for tuning flag, offset, field and blink
   always_comb begin
      tuning_d    = (bus.sys_status == S_TUNING) || (bus.sys_status == S_ALARMTUNING);
      offset_d    = offset_q;
      field_d     = field_q;
      blink_d     = blink_q;
      blink_cnt_d = blink_cnt_q;
      edit        = key_sel_p | key_up_p | key_dn_p | up_tick | down_tick;
      if (!tuning_d) begin
         offset_d    = OFFSET_INIT;
         field_d     = FIELD_SEC;
         blink_d     = 1'b0;
         blink_cnt_d = '0;
      end else if (!tuning_q) begin
         // Entering tuning: start from zero offset with the field lit
         offset_d    = OFFSET_INIT;
         field_d     = FIELD_SEC;
         blink_d     = 1'b1;
         blink_cnt_d = '0;
      end else begin
         if (key_cf_p) begin
            offset_d = OFFSET_INIT;
         end else if (key_sel_p) begin
            field_d = next_field(field_q);
         end else if (key_up_p || up_tick) begin
            offset_d = off_up;
         end else if (key_dn_p || down_tick) begin
            offset_d = off_dn;
         end
         // Any edit holds the blink on for a full half-period so the new value is seen
         if (edit) begin
            blink_d     = 1'b1;
            blink_cnt_d = '0;
         end else if (blink_cnt_q == BLINK_HALF - 1) begin
            blink_d     = ~blink_q;
            blink_cnt_d = '0;
         end else begin
            blink_cnt_d = blink_cnt_q + 32'd1;
         end
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tuning_q    <= 1'b0;
         offset_q    <= OFFSET_INIT;
         field_q     <= FIELD_SEC;
         blink_q     <= 1'b0;
         blink_cnt_q <= '0;
      end else begin
         tuning_q    <= tuning_d;
         offset_q    <= offset_d;
         field_q     <= field_d;
         blink_q     <= blink_d;
         blink_cnt_q <= blink_cnt_d;
      end
   end

   assign bus.offset    = offset_q;
   assign bus.field_sel = field_q;
   assign bus.blink     = blink_q;
   assign bus.tuning    = tuning_q;

endmodule

// File: tb/tb_offset_tuner.sv
module tb_offset_tuner;

   localparam int HOLD   = 10;
   localparam int REPEAT = 3;
   localparam int BLINK  = 4;
   localparam int BIAS   = 524287;   // 0x7ffff
   localparam int MAXD   = 86399;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: signed offset in seconds and field index
   int m_delta = 0;
   int m_field = 0;

   offset_tuner_if bus ();

   offset_tuner #(
      .HOLD_CYCLES   (HOLD),
      .REPEAT_CYCLES (REPEAT),
      .BLINK_HALF    (BLINK)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int step_size(input int f);
      return (f == 0) ? 1 : (f == 1) ? 60 : 3600;
   endfunction

   function automatic logic [31:0] exp_off();
      return 32'(BIAS + m_delta);
   endfunction

   task automatic m_apply(input logic [3:0] p);
      int s;
      s = step_size(m_field);
      case (p)
         4'b0001: m_delta = (m_delta + s > MAXD)  ? MAXD  : m_delta + s;
         4'b0010: m_delta = (m_delta - s < -MAXD) ? -MAXD : m_delta - s;
         4'b0100: m_field = (m_field + 1) % 3;
         4'b1000: m_delta = 0;
         default: ;
      endcase
   endtask

   task automatic press(input logic [3:0] p, input logic [3:0] held);
      bus.neg_keys_filtered = p;
      bus.keys_held         = held;
      step();
      bus.neg_keys_filtered = 4'b0000;
      m_apply(p);
   endtask

   // Repeat ticks seen by observation j (j=1 is the cycle after the pulse), key held throughout
   function automatic int n_ticks(input int j);
      return (j - 1 >= HOLD) ? 1 + (j - 1 - HOLD) / REPEAT : 0;
   endfunction

   initial begin
      logic [3:0] p;
      int r;

      rst_n                 = 1'b0;
      bus.sys_status        = 3'd0;
      bus.neg_keys_filtered = 4'b0000;
      bus.keys_held         = 4'b0000;
      step();
      step();
      chk("reset_offset", 32'(bus.offset), 32'h7ffff);
      chk("reset_field", 32'(bus.field_sel), 32'd0);
      chk("reset_blink", 32'(bus.blink), 32'd0);
      chk("reset_tuning", 32'(bus.tuning), 32'd0);

      // Enter tuning: blink starts lit and toggles after BLINK cycles
      rst_n          = 1'b1;
      bus.sys_status = 3'd3;
      step();
      chk("entry_tuning", 32'(bus.tuning), 32'd1);
      chk("entry_blink", 32'(bus.blink), 32'd1);
      chk("entry_offset", 32'(bus.offset), 32'h7ffff);
      repeat (BLINK - 1) step();
      chk("blink_still_on", 32'(bus.blink), 32'd1);
      step();
      chk("blink_toggled", 32'(bus.blink), 32'd0);

      // Hours step and confirm
      press(4'b0100, 4'b0000);
      chk("sel_blink_forced", 32'(bus.blink), 32'd1);
      chk("sel_field_min", 32'(bus.field_sel), 32'd1);
      press(4'b0100, 4'b0000);
      chk("sel_field_hour", 32'(bus.field_sel), 32'd2);
      press(4'b0001, 4'b0000);
      chk("hour_up", 32'(bus.offset), 32'h80e0f);
      press(4'b1000, 4'b0000);
      chk("confirm_offset", 32'(bus.offset), 32'h7ffff);
      chk("confirm_field", 32'(bus.field_sel), 32'd2);

      // Positive saturation with hours, then step down in seconds
      for (int i = 0; i < 24; i++) begin
         press(4'b0001, 4'b0000);
         chk("hour_sweep_up", 32'(bus.offset), exp_off());
      end
      chk("sat_high", 32'(bus.offset), 32'h9517e);
      press(4'b0001, 4'b0000);
      chk("sat_high_hold", 32'(bus.offset), 32'h9517e);
      press(4'b0100, 4'b0000);
      chk("wrap_field_sec", 32'(bus.field_sel), 32'd0);
      press(4'b0010, 4'b0000);
      chk("sec_down_from_sat", 32'(bus.offset), 32'h9517d);
      press(4'b1000, 4'b0000);

      // Negative steps in minutes
      press(4'b0100, 4'b0000);
      press(4'b0010, 4'b0000);
      press(4'b0010, 4'b0000);
      chk("min_down_twice", 32'(bus.offset), 32'h7ff87);

      // Simultaneous presses are dropped
      press(4'b0001, 4'b0000);
      press(4'b0011, 4'b0000);
      chk("illegal_0011", 32'(bus.offset), exp_off());
      press(4'b1100, 4'b0000);
      chk("illegal_1100", 32'(bus.offset), exp_off());
      chk("illegal_field", 32'(bus.field_sel), 32'(m_field));

      // Negative saturation with hours
      press(4'b1000, 4'b0000);
      press(4'b0100, 4'b0000);
      for (int i = 0; i < 25; i++) press(4'b0010, 4'b0000);
      chk("sat_low", 32'(bus.offset), 32'h6ae80);

      // Randomized key pulses against the model
      for (int i = 0; i < 300; i++) begin
         r = int'($urandom_range(0, 9));
         if (r <= 3)      p = 4'b0001;
         else if (r <= 6) p = 4'b0010;
         else if (r == 7) p = 4'b0100;
         else if (r == 8) p = 4'b1000;
         else begin
            p = 4'($urandom_range(0, 15));
            if ($countones(p) < 2) p = 4'b1111;
         end
         press(p, 4'b0000);
         chk("rand_offset", 32'(bus.offset), exp_off());
         chk("rand_field", 32'(bus.field_sel), 32'(m_field));
      end

      // Auto-repeat at seconds: pulse steps once, then ticks while held
      press(4'b1000, 4'b0000);
      while (m_field != 0) press(4'b0100, 4'b0000);
      press(4'b0001, 4'b0001);
      chk("rpt_pulse", 32'(bus.offset), exp_off());
      for (int j = 2; j <= 20; j++) begin
         step();
         chk("rpt_hold", 32'(bus.offset), 32'(BIAS + 1 + n_ticks(j)));
      end
      chk("rpt_total", 32'(bus.offset), 32'(BIAS + 5));
      bus.keys_held = 4'b0000;
      for (int j = 0; j < 10; j++) begin
         step();
         chk("rpt_released", 32'(bus.offset), 32'(BIAS + 5));
      end

      // Reset while repeating in minutes
      press(4'b1000, 4'b0000);
      while (m_field != 1) press(4'b0100, 4'b0000);
      press(4'b0001, 4'b0001);
      for (int j = 2; j <= 15; j++) step();
      chk("rst_pre_repeat", 32'(bus.offset), 32'(BIAS + 60 * (1 + n_ticks(15))));
      rst_n = 1'b0;
      step();
      chk("rst_mid_offset", 32'(bus.offset), 32'h7ffff);
      chk("rst_mid_field", 32'(bus.field_sel), 32'd0);
      chk("rst_mid_blink", 32'(bus.blink), 32'd0);
      chk("rst_mid_tuning", 32'(bus.tuning), 32'd0);
      rst_n   = 1'b1;
      m_delta = 0;
      m_field = 0;
      for (int j = 0; j < 12; j++) begin
         step();
         chk("rst_no_tick", 32'(bus.offset), 32'h7ffff);
      end
      bus.keys_held = 4'b0000;

      // Outside tuning keys do nothing
      bus.sys_status = 3'd1;
      step();
      step();
      press(4'b0001, 4'b0000);
      chk("idle_offset", 32'(bus.offset), 32'h7ffff);
      chk("idle_tuning", 32'(bus.tuning), 32'd0);
      chk("idle_blink", 32'(bus.blink), 32'd0);
      chk("idle_field", 32'(bus.field_sel), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
